ps2_keyboard_led_commander: RTL
===============================

// Module: ps2_keyboard_led_commander
// PURPOSE
//  Host-to-keyboard command sequencer on the PS/2 path. Drives the send side of PS2_Controller
//  with the Set-LEDs command (0xED + LED byte), consumes the keyboard's 0xFA/0xFE replies and
//  retries on resend or timeout. Reports completion or failure.
//  Scan-code decoding of key make/break bytes stays with the existing receive logic, which
//  sees the same received byte stream.
// PARAMETERS
//  ACK_TIMEOUT_CYCLES  1000000  cycles to wait for a reply after a byte is sent (20 ms @ 50 MHz)
//  MAX_RETRIES         3        resends allowed per byte before failure
//  CMD_SET_LEDS        8'hED    command opcode sent first
// PORTS
//  CLOCK_50                      in   1  system clock; all logic on posedge
//  resetn                        in   1  asynchronous, active-low reset
//  led_request                   in   1  1-cycle pulse: update keyboard LEDs to led_value
//  led_value                     in   3  {caps,num,scroll} = bits [2:0] of the LED byte
//  command_was_sent              in   1  PS2_Controller: current byte transmitted
//  error_communication_timed_out in   1  PS2_Controller: transmit failed
//  received_data                 in   8  PS2_Controller received byte
//  received_new_data             in   1  1-cycle strobe, CLOCK_50 domain, received_data valid
//  command_to_send               out  8  byte presented to PS2_Controller
//  send_command                  out  1  1-cycle pulse: start transmit of command_to_send
//  busy                          out  1  high from request accept until done/fail
//  done                          out  1  1-cycle pulse: both bytes acknowledged
//  error                         out  1  1-cycle pulse: retries exhausted, sequence abandoned
//  led_state                     out  3  last LED value acknowledged by keyboard
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; pending flag, counters, latched value cleared.
//  States: IDLE, SEND_CMD, WAIT_SENT_CMD, WAIT_ACK_CMD, SEND_ARG, WAIT_SENT_ARG, WAIT_ACK_ARG.
//  IDLE: led_request (or pending set) -> latch value, clear retry count, busy=1, go SEND_CMD.
//  SEND_*: command_to_send = 0xED or {5'b0,latched value}; send_command=1 for exactly this cycle.
//    Go to WAIT_SENT_*. command_to_send stays stable until the next SEND_* or IDLE.
//  WAIT_SENT_*: command_was_sent -> clear timeout counter, go WAIT_ACK_*.
//    error_communication_timed_out -> retry the same byte.
//    If both assert in one cycle, command_was_sent wins.
//  WAIT_ACK_*: on received_new_data:
//    0xFA -> ACK_CMD: go SEND_ARG, retry count cleared; ACK_ARG: update led_state, done=1, IDLE.
//    0xFE -> retry the same byte.
//    Any other byte is ignored (stray scan code); the timeout counter is not reset.
//    The counter reaching ACK_TIMEOUT_CYCLES-1 without 0xFA/0xFE -> retry the same byte.
//    A byte arriving on the expiry cycle takes priority over the timeout.
//  Retry: retry_count+1; if new count > MAX_RETRIES then error=1, busy=0, IDLE (led_state kept);
//    else SEND_* of the same byte. Byte attempts per byte = MAX_RETRIES+1 max.
//  Requests while busy: set pending, overwrite latched-next value with newest led_value.
//    After done/error, the FSM returns to IDLE for one cycle, then starts the pending sequence.
//    Multiple requests coalesce into one. A request in the same cycle as done is kept pending.
//  busy falls in the cycle done/error pulses, rising again 2 cycles later if pending.
//  Widths: timeout counter $clog2(ACK_TIMEOUT_CYCLES); retry counter $clog2(MAX_RETRIES+2);
//    both saturate, no wrap.
//  Reset mid-sequence: immediate return to reset values; the keyboard may be left awaiting
//    an arg byte. The next request restarts with 0xED, and the keyboard accepts it as a new command.
// TESTING
//  1 req led_value=3'b100, bench sends 0xFA after each send -> bytes ED,04; done 1 cycle; led_state=100.
//  2 0xFE after ED once -> ED transmitted twice, then 04; done; no error.
//  3 Never reply, ACK_TIMEOUT_CYCLES=100, MAX_RETRIES=3 -> ED sent 4x ~100 cycles apart;
//    error pulse; led_state unchanged; busy=0.
//  4 Reqs 001 then 010,011 while busy -> first completes with 01; exactly one more sequence
//    sends ED,03.
//  5 Scan code 0x1C in WAIT_ACK_ARG, then 0xFA -> 0x1C ignored, done.
//    error_communication_timed_out in WAIT_SENT_CMD -> ED resent.
//  6 resetn low during WAIT_ACK_ARG -> all outputs 0 asynchronously; new req after release
//    restarts at ED.

Source files
------------

// File: rtl/ps2_keyboard_led_commander_if.sv
// Byte-level handshake between the LED command sequencer and PS2_Controller.
// The master side presents bytes to send; the slave side reports transmit status and received bytes.
interface ps2_keyboard_led_commander_if;
    logic [7:0] command_to_send;
    logic       send_command;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic [7:0] received_data;
    logic       received_new_data;

    modport master (
        output command_to_send,
        output send_command,
        input  command_was_sent,
        input  error_communication_timed_out,
        input  received_data,
        input  received_new_data
    );

    modport slave (
        input  command_to_send,
        input  send_command,
        output command_was_sent,
        output error_communication_timed_out,
        output received_data,
        output received_new_data
    );
endinterface

// File: rtl/ps2_keyboard_led_commander.sv
// Sends the Set-LEDs command (opcode + LED byte) to a PS/2 keyboard, handles ACK/resend/timeout
// with bounded retries, and coalesces requests that arrive while a sequence is in flight.
module ps2_keyboard_led_commander #(
    parameter int unsigned ACK_TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter logic [7:0]  CMD_SET_LEDS       = 8'hED
) (
    input  logic                                CLOCK_50,
    input  logic                                resetn,
    input  logic                                led_request,
    input  logic [2:0]                          led_value,
    ps2_keyboard_led_commander_if.master        ps2,
    output logic                                busy,
    output logic                                done,
    output logic                                error,
    output logic [2:0]                          led_state
);

    localparam int unsigned TW = $clog2(ACK_TIMEOUT_CYCLES);
    localparam int unsigned RW = $clog2(MAX_RETRIES + 2);
    localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT_CYCLES - 32'd1);
    localparam logic [TW-1:0] T_SAT  = {TW{1'b1}};
    localparam logic [RW-1:0] R_LIMIT = RW'(MAX_RETRIES);
    localparam logic [RW-1:0] R_SAT   = {RW{1'b1}};
    localparam logic [7:0] BYTE_ACK    = 8'hFA;
    localparam logic [7:0] BYTE_RESEND = 8'hFE;

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_SEND_CMD      = 3'd1,
        S_WAIT_SENT_CMD = 3'd2,
        S_WAIT_ACK_CMD  = 3'd3,
        S_SEND_ARG      = 3'd4,
        S_WAIT_SENT_ARG = 3'd5,
        S_WAIT_ACK_ARG  = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic          send_q, send_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [2:0]    led_state_q, led_state_d;
    logic [2:0]    latched_q, latched_d;
    logic          pending_q, pending_d;
    logic [2:0]    next_val_q, next_val_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          do_retry_s;
    logic          rx_ack_s;
    logic          rx_resend_s;
    logic          arg_phase_s;
    logic [RW-1:0] retry_inc_s;
    logic [TW-1:0] timer_inc_s;

    // Sequencer next-state, outputs and request/retry bookkeeping.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        send_d      = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        led_state_d = led_state_q;
        latched_d   = latched_q;
        retry_d     = retry_q;
        timer_d     = timer_q;
        do_retry_s  = 1'b0;
        rx_ack_s    = ps2.received_new_data && (ps2.received_data == BYTE_ACK);
        rx_resend_s = ps2.received_new_data && (ps2.received_data == BYTE_RESEND);
        retry_inc_s = (retry_q == R_SAT) ? retry_q : retry_q + RW'(1);
        timer_inc_s = (timer_q == T_SAT) ? timer_q : timer_q + TW'(1);
        arg_phase_s = (state_q == S_SEND_ARG) || (state_q == S_WAIT_SENT_ARG) ||
                      (state_q == S_WAIT_ACK_ARG);

        // The IDLE cycle carrying done/error still counts as busy, so requests then are deferred.
        if (led_request && ((state_q != S_IDLE) || done_q || error_q)) begin
            pending_d  = 1'b1;
            next_val_d = led_value;
        end else begin
            pending_d  = pending_q;
            next_val_d = next_val_q;
        end

        case (state_q)
            S_IDLE: begin
                if (!done_q && !error_q && (led_request || pending_q)) begin
                    latched_d = led_request ? led_value : next_val_q;
                    pending_d = 1'b0;
                    retry_d   = {RW{1'b0}};
                    busy_d    = 1'b1;
                    cmd_d     = CMD_SET_LEDS;
                    send_d    = 1'b1;
                    state_d   = S_SEND_CMD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND_CMD: state_d = S_WAIT_SENT_CMD;
            S_SEND_ARG: state_d = S_WAIT_SENT_ARG;
            S_WAIT_SENT_CMD, S_WAIT_SENT_ARG: begin
                if (ps2.command_was_sent) begin
                    timer_d = {TW{1'b0}};
                    state_d = arg_phase_s ? S_WAIT_ACK_ARG : S_WAIT_ACK_CMD;
                end else if (ps2.error_communication_timed_out) begin
                    do_retry_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_WAIT_ACK_CMD, S_WAIT_ACK_ARG: begin
                timer_d = timer_inc_s;
                if (rx_ack_s && !arg_phase_s) begin
                    retry_d = {RW{1'b0}};
                    cmd_d   = {5'b00000, latched_q};
                    send_d  = 1'b1;
                    state_d = S_SEND_ARG;
                end else if (rx_ack_s) begin
                    led_state_d = latched_q;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else if (rx_resend_s || (timer_q == T_LAST)) begin
                    do_retry_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        if (do_retry_s) begin
            if (retry_inc_s > R_LIMIT) begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end else begin
                retry_d = retry_inc_s;
                send_d  = 1'b1;
                state_d = arg_phase_s ? S_SEND_ARG : S_SEND_CMD;
            end
        end else begin
            error_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cmd_q       <= 8'h00;
            send_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            led_state_q <= 3'b000;
            latched_q   <= 3'b000;
            pending_q   <= 1'b0;
            next_val_q  <= 3'b000;
            retry_q     <= {RW{1'b0}};
            timer_q     <= {TW{1'b0}};
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            send_q      <= send_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            led_state_q <= led_state_d;
            latched_q   <= latched_d;
            pending_q   <= pending_d;
            next_val_q  <= next_val_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
        end
    end

    assign ps2.command_to_send = cmd_q;
    assign ps2.send_command    = send_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign error               = error_q;
    assign led_state           = led_state_q;

endmodule
